// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage of the pipelined RISC-V core.
// Owns the program counter and presents it as the fetch address. Captures the
// returned word into the IF/ID register. Handles stalls, redirects with flush,
// and out-of-range fetches with a sticky fault.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_BYTES = 16,
    parameter logic [31:0] NOP_INST  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] instAddr,
    input  logic [31:0] inst,
    output logic [31:0] if_id_inst,
    output logic [63:0] if_id_pc,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic        misaligned
);

    // Highest byte address at which a full 32-bit word can still be fetched.
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 4);

    // True when a byte address is not on a 4-byte boundary.
    function automatic logic isMisaligned(input logic [63:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    logic [63:0] pc_r;
    logic [31:0] ifIdInst_r;
    logic [63:0] ifIdPc_r;
    logic        ifIdValid_r;
    logic        fetchFault_r;
    logic        misaligned_r;

    logic [63:0] pcNext_s;
    logic [31:0] ifIdInstNext_s;
    logic [63:0] ifIdPcNext_s;
    logic        ifIdValidNext_s;
    logic        fetchFaultNext_s;
    logic        misalignedNext_s;
    logic        outOfRange_s;

    // The current PC is checked against memory bounds in the same cycle it is presented.
    assign outOfRange_s = (pc_r > LAST_ADDR);

    // Next-state selection: redirect beats fault hold, which beats stall, which beats normal fetch.
    always_comb begin
        pcNext_s         = pc_r;
        ifIdInstNext_s   = ifIdInst_r;
        ifIdPcNext_s     = ifIdPc_r;
        ifIdValidNext_s  = ifIdValid_r;
        fetchFaultNext_s = fetchFault_r;
        misalignedNext_s = 1'b0;
        if (redirect) begin
            // The low two bits are dropped; the pulse tells EX the target was not word-aligned.
            pcNext_s         = {redirect_pc[63:2], 2'b00};
            ifIdInstNext_s   = NOP_INST;
            ifIdPcNext_s     = 64'd0;
            ifIdValidNext_s  = 1'b0;
            fetchFaultNext_s = 1'b0;
            misalignedNext_s = isMisaligned(redirect_pc);
        end else if (outOfRange_s) begin
            // Memory data is meaningless here; freeze the PC and keep feeding bubbles.
            pcNext_s         = pc_r;
            ifIdInstNext_s   = NOP_INST;
            ifIdPcNext_s     = 64'd0;
            ifIdValidNext_s  = 1'b0;
            fetchFaultNext_s = 1'b1;
        end else if (stall) begin
            pcNext_s         = pc_r;
            ifIdInstNext_s   = ifIdInst_r;
            ifIdPcNext_s     = ifIdPc_r;
            ifIdValidNext_s  = ifIdValid_r;
            fetchFaultNext_s = fetchFault_r;
        end else begin
            pcNext_s         = pc_r + 64'd4;
            ifIdInstNext_s   = inst;
            ifIdPcNext_s     = pc_r;
            ifIdValidNext_s  = 1'b1;
            fetchFaultNext_s = fetchFault_r;
        end
    end

    // State register with synchronous reset; reset masks any concurrent redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            ifIdInst_r   <= NOP_INST;
            ifIdPc_r     <= 64'd0;
            ifIdValid_r  <= 1'b0;
            fetchFault_r <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            pc_r         <= pcNext_s;
            ifIdInst_r   <= ifIdInstNext_s;
            ifIdPc_r     <= ifIdPcNext_s;
            ifIdValid_r  <= ifIdValidNext_s;
            fetchFault_r <= fetchFaultNext_s;
            misaligned_r <= misalignedNext_s;
        end
    end

    assign instAddr    = pc_r;
    assign if_id_inst  = ifIdInst_r;
    assign if_id_pc    = ifIdPc_r;
    assign if_id_valid = ifIdValid_r;
    assign fetch_fault = fetchFault_r;
    assign misaligned  = misaligned_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a 16-byte instruction image.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] W0  = 32'h0F053483;
    localparam logic [31:0] W1  = 32'h009A84B3;
    localparam logic [31:0] W2  = 32'h00148493;
    localparam logic [31:0] W3  = 32'h0E953823;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] instAddr;
    logic [31:0] inst;
    logic [31:0] if_id_inst;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_fault;
    logic        misaligned;

    int checks;
    int errors;

    instruction_fetch #(
        .RESET_PC (64'h0),
        .MEM_BYTES(16),
        .NOP_INST (32'h00000013)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instAddr   (instAddr),
        .inst       (inst),
        .if_id_inst (if_id_inst),
        .if_id_pc   (if_id_pc),
        .if_id_valid(if_id_valid),
        .fetch_fault(fetch_fault),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency instruction memory; garbage outside the image.
    always_comb begin
        case (instAddr)
            64'd0:   inst = W0;
            64'd4:   inst = W1;
            64'd8:   inst = W2;
            64'd12:  inst = W3;
            default: inst = 32'hDEADBEEF;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic [63:0] ePc, input logic [31:0] eInst,
                          input logic [63:0] eIfPc, input logic eValid, input logic eFault,
                          input logic eMis);
        chk({tag, ".pc"},    instAddr,           ePc);
        chk({tag, ".inst"},  {32'd0, if_id_inst}, {32'd0, eInst});
        chk({tag, ".ifpc"},  if_id_pc,           eIfPc);
        chk({tag, ".valid"}, {63'd0, if_id_valid}, {63'd0, eValid});
        chk({tag, ".fault"}, {63'd0, fetch_fault}, {63'd0, eFault});
        chk({tag, ".mis"},   {63'd0, misaligned},  {63'd0, eMis});
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'd0;

        tick();
        tick();
        chkAll("reset", 64'd0, NOP, 64'd0, 1'b0, 1'b0, 1'b0);

        // Free-run from reset.
        reset = 1'b0;
        tick();
        chkAll("run0", 64'd4, W0, 64'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chkAll("run1", 64'd8, W1, 64'd4, 1'b1, 1'b0, 1'b0);

        // Stall three cycles with pc at 8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chkAll("stall", 64'd8, W1, 64'd4, 1'b1, 1'b0, 1'b0);
        end
        stall = 1'b0;
        tick();
        chkAll("run2", 64'd12, W2, 64'd8, 1'b1, 1'b0, 1'b0);
        tick();
        chkAll("run3", 64'd16, W3, 64'd12, 1'b1, 1'b0, 1'b0);

        // pc = 16 is out of range: fault, bubble, pc frozen.
        tick();
        chkAll("fault", 64'd16, NOP, 64'd0, 1'b0, 1'b1, 1'b0);
        stall = 1'b1;
        tick();
        chkAll("faultStall", 64'd16, NOP, 64'd0, 1'b0, 1'b1, 1'b0);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chkAll("faultHold", 64'd16, NOP, 64'd0, 1'b0, 1'b1, 1'b0);
        end

        // Redirect to 0 clears the fault.
        redirect    = 1'b1;
        redirect_pc = 64'd0;
        tick();
        chkAll("redir0", 64'd0, NOP, 64'd0, 1'b0, 1'b0, 1'b0);
        redirect = 1'b0;
        tick();
        chkAll("afterRedir0", 64'd4, W0, 64'd0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chkAll("runTo12", 64'd12, W2, 64'd8, 1'b1, 1'b0, 1'b0);

        // Redirect to 4 wins over a simultaneous stall.
        redirect    = 1'b1;
        redirect_pc = 64'd4;
        stall       = 1'b1;
        tick();
        chkAll("redirStall", 64'd4, NOP, 64'd0, 1'b0, 1'b0, 1'b0);
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        chkAll("afterRedir4", 64'd8, W1, 64'd4, 1'b1, 1'b0, 1'b0);

        // Misaligned target 0x6 aligns down to 4 and pulses misaligned.
        redirect    = 1'b1;
        redirect_pc = 64'd6;
        tick();
        chkAll("redirMis", 64'd4, NOP, 64'd0, 1'b0, 1'b0, 1'b1);
        redirect = 1'b0;
        tick();
        chkAll("afterMis", 64'd8, W1, 64'd4, 1'b1, 1'b0, 1'b0);

        // Top of the address space faults without wrapping.
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFD;
        tick();
        chkAll("redirTop", 64'hFFFF_FFFF_FFFF_FFFC, NOP, 64'd0, 1'b0, 1'b0, 1'b1);
        redirect = 1'b0;
        tick();
        chkAll("topFault", 64'hFFFF_FFFF_FFFF_FFFC, NOP, 64'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chkAll("topHold", 64'hFFFF_FFFF_FFFF_FFFC, NOP, 64'd0, 1'b0, 1'b1, 1'b0);

        // Back into range, then reset together with a redirect.
        redirect    = 1'b1;
        redirect_pc = 64'd8;
        tick();
        redirect = 1'b0;
        tick();
        chkAll("preReset", 64'd12, W2, 64'd8, 1'b1, 1'b0, 1'b0);
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'd6;
        tick();
        chkAll("resetRedir", 64'd0, NOP, 64'd0, 1'b0, 1'b0, 1'b0);
        reset    = 1'b0;
        redirect = 1'b0;
        tick();
        chkAll("afterReset", 64'd4, W0, 64'd0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
